// File: rtl/rgb_stream_packer.sv
// rgb_stream_packer
//   Packs a stream of 24-bit RGB pixels into a gapless 32-bit AXI4-Stream
//   (4 pixels -> 3 words, byte 0 = tdata[7:0]). A line ending off a word
//   boundary is closed with a partial word whose tkeep marks the valid bytes.
//   Start-of-frame rides tuser on the first word carrying a tagged pixel's
//   data; end-of-line is reported on tlast.
//
// Ports
//   aclk               clock
//   aresetn            synchronous active-low reset
//   r, g, b            pixel components (pixel = {r, g, b})
//   valid, sof, eol    pixel qualifier, first-of-frame, last-of-line
//   in_stream_ready    pixel accepted when valid && in_stream_ready
//   out_stream_*       AXI4-Stream master (tdata/tkeep/tlast/tuser/tvalid/tready)

module rgb_stream_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  input  logic        valid,
  input  logic        sof,
  input  logic        eol,
  output logic        in_stream_ready,
  output logic [31:0] out_stream_tdata,
  output logic [3:0]  out_stream_tkeep,
  output logic        out_stream_tlast,
  output logic        out_stream_tuser,
  input  logic        out_stream_tready,
  output logic        out_stream_tvalid
);

  typedef enum logic [0:0] {StPack, StFlush} state_e;

  state_e      state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [23:0] res_q, res_d;
  logic        sof_pend_q, sof_pend_d;
  logic [3:0]  flush_keep_q, flush_keep_d;

  logic [31:0] tdata_q, tdata_d;
  logic [3:0]  tkeep_q, tkeep_d;
  logic        tlast_q, tlast_d;
  logic        tuser_q, tuser_d;
  logic        tvalid_q, tvalid_d;

  logic        out_free;
  logic        accept;
  logic        sof_eff;
  logic        load;
  logic [31:0] ld_data;
  logic [3:0]  ld_keep;
  logic        ld_last;
  logic [23:0] pix;

  assign pix             = {r, g, b};
  // Output register can take a new word if empty or drained this cycle.
  assign out_free        = !tvalid_q || out_stream_tready;
  assign in_stream_ready = aresetn && (state_q == StPack) && out_free;
  assign accept          = valid && in_stream_ready;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    res_d        = res_q;
    flush_keep_d = flush_keep_q;
    sof_pend_d   = sof_pend_q;
    tdata_d      = tdata_q;
    tkeep_d      = tkeep_q;
    tlast_d      = tlast_q;
    tuser_d      = tuser_q;
    tvalid_d     = tvalid_q && !out_stream_tready;
    load         = 1'b0;
    ld_data      = '0;
    ld_keep      = '0;
    ld_last      = 1'b0;

    unique case (state_q)
      StPack: begin
        if (accept) begin
          unique case (phase_q)
            2'd0: begin
              if (eol) begin
                load    = 1'b1;
                ld_data = {PAD_BYTE, pix};
                ld_keep = 4'h7;
                ld_last = 1'b1;
                res_d   = '0;
              end else begin
                res_d   = pix;
                phase_d = 2'd1;
              end
            end
            2'd1: begin
              load    = 1'b1;
              ld_data = {pix[7:0], res_q};
              ld_keep = 4'hF;
              res_d   = {8'h00, pix[23:8]};
              if (eol) begin
                // Two leftover bytes go out in a following flush word.
                flush_keep_d = 4'h3;
                state_d      = StFlush;
                phase_d      = 2'd0;
              end else begin
                phase_d = 2'd2;
              end
            end
            2'd2: begin
              load    = 1'b1;
              ld_data = {pix[15:0], res_q[15:0]};
              ld_keep = 4'hF;
              res_d   = {16'h0000, pix[23:16]};
              if (eol) begin
                flush_keep_d = 4'h1;
                state_d      = StFlush;
                phase_d      = 2'd0;
              end else begin
                phase_d = 2'd3;
              end
            end
            2'd3: begin
              load    = 1'b1;
              ld_data = {pix, res_q[7:0]};
              ld_keep = 4'hF;
              ld_last = eol;
              res_d   = '0;
              phase_d = 2'd0;
            end
          endcase
        end
      end
      StFlush: begin
        if (out_free) begin
          load    = 1'b1;
          ld_data = flush_keep_q[1] ? {PAD_BYTE, PAD_BYTE, res_q[15:0]}
                                    : {PAD_BYTE, PAD_BYTE, PAD_BYTE, res_q[7:0]};
          ld_keep = flush_keep_q;
          ld_last = 1'b1;
          res_d   = '0;
          state_d = StPack;
        end
      end
    endcase

    // A sof tag rides the next word loaded, which may be the tagged pixel's own.
    sof_eff = sof_pend_q || (accept && sof);
    if (load) begin
      tvalid_d   = 1'b1;
      tdata_d    = ld_data;
      tkeep_d    = ld_keep;
      tlast_d    = ld_last;
      tuser_d    = sof_eff;
      sof_pend_d = 1'b0;
    end else begin
      sof_pend_d = sof_eff;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= StPack;
      phase_q      <= 2'd0;
      res_q        <= '0;
      flush_keep_q <= '0;
      sof_pend_q   <= 1'b0;
      tdata_q      <= '0;
      tkeep_q      <= '0;
      tlast_q      <= 1'b0;
      tuser_q      <= 1'b0;
      tvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      res_q        <= res_d;
      flush_keep_q <= flush_keep_d;
      sof_pend_q   <= sof_pend_d;
      tdata_q      <= tdata_d;
      tkeep_q      <= tkeep_d;
      tlast_q      <= tlast_d;
      tuser_q      <= tuser_d;
      tvalid_q     <= tvalid_d;
    end
  end

  assign out_stream_tdata  = tdata_q;
  assign out_stream_tkeep  = tkeep_q;
  assign out_stream_tlast  = tlast_q;
  assign out_stream_tuser  = tuser_q;
  assign out_stream_tvalid = tvalid_q;

endmodule

// File: tb/tb_rgb_stream_packer.sv
// Bench for rgb_stream_packer: pixels are modelled as a byte stream per line
// (byte 0 of a pixel = blue), cut into 4-byte words with the line tail padded.

module tb_rgb_stream_packer;

  localparam logic [7:0] Pad = 8'hA5;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [7:0]  r = '0, g = '0, b = '0;
  logic        valid = 1'b0, sof = 1'b0, eol = 1'b0;
  logic        in_stream_ready;
  logic [31:0] out_stream_tdata;
  logic [3:0]  out_stream_tkeep;
  logic        out_stream_tlast;
  logic        out_stream_tuser;
  logic        out_stream_tready = 1'b0;
  logic        out_stream_tvalid;

  always #5 aclk = ~aclk;

  rgb_stream_packer #(.PAD_BYTE(Pad)) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .r                 (r),
    .g                 (g),
    .b                 (b),
    .valid             (valid),
    .sof               (sof),
    .eol               (eol),
    .in_stream_ready   (in_stream_ready),
    .out_stream_tdata  (out_stream_tdata),
    .out_stream_tkeep  (out_stream_tkeep),
    .out_stream_tlast  (out_stream_tlast),
    .out_stream_tuser  (out_stream_tuser),
    .out_stream_tready (out_stream_tready),
    .out_stream_tvalid (out_stream_tvalid)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int words_seen = 0, tlast_seen = 0, partial_seen = 0;
  bit rand_bp = 1'b0;

  logic [37:0] expq[$];    // {tuser, tlast, tkeep, tdata}
  logic [8:0]  bytebuf[$]; // {sof tag, byte}

  function automatic void emit_word(int n, bit last);
    logic [31:0] d;
    logic [3:0]  k;
    logic        u;
    logic [8:0]  bt;
    d = {4{Pad}};
    k = '0;
    u = 1'b0;
    for (int i = 0; i < n; i++) begin
      bt = bytebuf.pop_front();
      d[8*i +: 8] = bt[7:0];
      k[i] = 1'b1;
      u = u | bt[8];
    end
    expq.push_back({u, last, k, d});
  endfunction

  function automatic void model_accept(logic [23:0] p, logic s, logic e);
    int n;
    bytebuf.push_back({s, p[7:0]});
    bytebuf.push_back({1'b0, p[15:8]});
    bytebuf.push_back({1'b0, p[23:16]});
    if (!e) begin
      while (bytebuf.size() >= 4) emit_word(4, 1'b0);
    end else begin
      while (bytebuf.size() > 0) begin
        n = (bytebuf.size() > 4) ? 4 : bytebuf.size();
        emit_word(n, bytebuf.size() == n);
      end
    end
  endfunction

  // Monitor: everything sampled at the falling edge, away from the active edge.
  always @(negedge aclk) begin
    logic [37:0] got, ew;
    if (aresetn && out_stream_tvalid && out_stream_tready) begin
      got = {out_stream_tuser, out_stream_tlast, out_stream_tkeep, out_stream_tdata};
      words_seen++;
      if (out_stream_tlast) tlast_seen++;
      if (out_stream_tkeep != 4'hF) partial_seen++;
      n_tests++;
      if (expq.size() == 0) begin
        n_fail++;
        $display("FAIL word_unexpected: got %h, required none", got);
      end else begin
        ew = expq.pop_front();
        if (got !== ew) begin
          n_fail++;
          $display("FAIL word_compare: got user/last/keep/data %h, required %h", got, ew);
        end
      end
    end
    if (valid && in_stream_ready) model_accept({r, g, b}, sof, eol);
    if (!aresetn) begin
      expq.delete();
      bytebuf.delete();
    end
  end

  always @(posedge aclk) begin
    if (rand_bp) begin
      #1;
      out_stream_tready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send_pixel(input logic [23:0] p, input logic s, input logic e,
                            output int waits);
    bit acc;
    {r, g, b} = p;
    sof = s;
    eol = e;
    valid = 1'b1;
    waits = 0;
    acc = 1'b0;
    for (int c = 0; c < 200 && !acc; c++) begin
      @(negedge aclk);
      acc = in_stream_ready;
      if (!acc) waits++;
      @(posedge aclk);
      #1;
    end
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL pixel_accept_timeout: got no accept, required accept within 200 cycles");
    end
    valid = 1'b0;
    sof = 1'b0;
    eol = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(negedge aclk);
      done = (expq.size() == 0) && !out_stream_tvalid;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d words pending, required 0", expq.size());
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic check_int(input string name, input int got, input int req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    out_stream_tready = 1'b1;
    valid = 1'b1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    n_tests++;
    if (in_stream_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got %b, required 0", in_stream_ready);
    end
    @(posedge aclk);
    #1;
    n_tests++;
    if ({out_stream_tvalid, out_stream_tlast, out_stream_tuser, out_stream_tkeep,
         out_stream_tdata} !== 39'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b l=%b u=%b k=%h d=%h, required all 0",
               out_stream_tvalid, out_stream_tlast, out_stream_tuser, out_stream_tkeep,
               out_stream_tdata);
    end
    valid = 1'b0;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  task automatic test_basic();
    int w0, t0, wt;
    w0 = words_seen;
    t0 = tlast_seen;
    send_pixel(24'h112233, 1'b1, 1'b0, wt);
    send_pixel(24'h445566, 1'b0, 1'b0, wt);
    send_pixel(24'h778899, 1'b0, 1'b0, wt);
    send_pixel(24'hAABBCC, 1'b0, 1'b1, wt);
    drain();
    check_int("basic_word_count", words_seen - w0, 3);
    check_int("basic_tlast_count", tlast_seen - t0, 1);
  endtask

  task automatic test_long_line();
    int w0, t0, p0, wt, stalls;
    w0 = words_seen;
    t0 = tlast_seen;
    p0 = partial_seen;
    stalls = 0;
    for (int i = 0; i < 640; i++) begin
      send_pixel(24'($urandom), i == 0, i == 639, wt);
      stalls += wt;
    end
    drain();
    check_int("long_ready_low_cycles", stalls, 0);
    check_int("long_word_count", words_seen - w0, 480);
    check_int("long_tlast_count", tlast_seen - t0, 1);
    check_int("long_partial_count", partial_seen - p0, 0);
  endtask

  task automatic test_eol_phase0();
    int w0, p0, wt;
    w0 = words_seen;
    p0 = partial_seen;
    for (int i = 0; i < 5; i++) send_pixel(24'($urandom), i == 0, i == 4, wt);
    drain();
    check_int("eol0_word_count", words_seen - w0, 4);
    check_int("eol0_partial_count", partial_seen - p0, 1);
  endtask

  task automatic test_eol_flush();
    int w0, wt, stalls;
    for (int n = 6; n <= 7; n++) begin
      w0 = words_seen;
      stalls = 0;
      for (int i = 0; i < n; i++) begin
        send_pixel(24'($urandom), i == 0, i == n - 1, wt);
        stalls += wt;
      end
      check_int("flush_line_stalls", stalls, 0);
      // Pixel right after the eol must wait out the flush cycle.
      send_pixel(24'($urandom), 1'b1, 1'b1, wt);
      check_int("flush_bubble_cycles", wt, 1);
      drain();
      check_int("flush_word_count", words_seen - w0, (3 * n + 3) / 4 + 1);
    end
  endtask

  task automatic test_stall();
    int wt;
    logic [31:0] held;
    logic [23:0] px[6];
    for (int i = 0; i < 6; i++) px[i] = 24'($urandom);
    send_pixel(px[0], 1'b1, 1'b0, wt);
    send_pixel(px[1], 1'b0, 1'b0, wt);
    out_stream_tready = 1'b0;
    held = out_stream_tdata;
    {r, g, b} = px[2];
    valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      n_tests++;
      if (out_stream_tvalid !== 1'b1 || out_stream_tdata !== held || in_stream_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold: got v=%b d=%h rdy=%b, required v=1 d=%h rdy=0",
                 out_stream_tvalid, out_stream_tdata, in_stream_ready, held);
      end
      @(posedge aclk);
      #1;
    end
    out_stream_tready = 1'b1;
    for (int i = 2; i < 6; i++) send_pixel(px[i], 1'b0, i == 5, wt);
    drain();
  endtask

  task automatic test_random_bp();
    int len, wt;
    rand_bp = 1'b1;
    for (int l = 0; l < 8; l++) begin
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++)
        send_pixel(24'($urandom), (i == 0) ? 1'($urandom_range(0, 1))
                                           : ($urandom_range(0, 7) == 0), i == len - 1, wt);
    end
    drain();
    rand_bp = 1'b0;
    @(posedge aclk);
    #2;
    out_stream_tready = 1'b1;
  endtask

  task automatic test_reset_midline();
    int w0, p0, wt;
    out_stream_tready = 1'b0;
    send_pixel(24'($urandom), 1'b1, 1'b0, wt);
    send_pixel(24'($urandom), 1'b0, 1'b0, wt);
    aresetn = 1'b0;
    @(negedge aclk);
    n_tests++;
    if (in_stream_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_ready: got %b, required 0", in_stream_ready);
    end
    @(posedge aclk);
    #1;
    n_tests++;
    if ({out_stream_tvalid, out_stream_tlast, out_stream_tuser, out_stream_tkeep,
         out_stream_tdata} !== 39'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got v=%b k=%h d=%h, required all 0",
               out_stream_tvalid, out_stream_tkeep, out_stream_tdata);
    end
    aresetn = 1'b1;
    out_stream_tready = 1'b1;
    w0 = words_seen;
    p0 = partial_seen;
    for (int i = 0; i < 4; i++) send_pixel(24'($urandom), i == 0, i == 3, wt);
    drain();
    check_int("midreset_word_count", words_seen - w0, 3);
    check_int("midreset_partial_count", partial_seen - p0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_long_line();
    test_eol_phase0();
    test_eol_flush();
    test_stall();
    test_random_bp();
    test_reset_midline();
    check_int("final_queue_empty", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
